decryption_state_ctrl: RTL and testbench
========================================

DECRYPTION_STATE_CTRL -- requirements
Module: decryption_state_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 iv_load  in  1  one-cycle strobe; loads iv into state.
REQ-005 iv  in  64  initial value; iv[63:48]->rs1, [47:32]->rs2, [31:16]->rs3, [15:0]->rs4.
REQ-006 ct_valid / ct_ready  in / out  1 / 1  ciphertext-word handshake.
REQ-007 ct_data  in  16  ciphertext word.
REQ-008 pt_valid / pt_ready  out / in  1 / 1  plaintext-word handshake.
REQ-009 pt_data  out  16  registered plaintext word.
REQ-010 core_datain  out  16  equals ct_data, combinational, to the 4-stage decryption datapath.
REQ-011 core_rs1..core_rs4  out  16 each  current rs1..rs4 register values.
REQ-012 core_dec1_in, core_dec2_out, core_dec3_out, core_dataout  in  16 each  intermediate and final datapath results for the current ct_data and rs.
REQ-013 block_cnt  out  16  blocks decrypted since the last iv_load.

Function
REQ-014 States: IDLE (no IV loaded) and RUN; reset enters IDLE; iv_load moves to RUN from either state.
REQ-015 ct_ready SHALL be 1 only when state==RUN, iv_load==0, and (pt_valid==0 or pt_ready==1).
REQ-016 Accept SHALL be ct_valid && ct_ready; on accept, pt_data <= core_dataout and pt_valid <= 1 at the next edge (latency 1 cycle).
REQ-017 pt_valid SHALL clear on pt_valid && pt_ready with no simultaneous accept; with a simultaneous accept it stays 1 and pt_data takes the new word (full throughput, 1 word/cycle).
REQ-018 While pt_valid && !pt_ready, pt_data and all state SHALL hold unchanged.
REQ-019 The 16-bit LFSR step SHALL be: nb = l[15]^l[14]^l[11]^l[9]^l[6]^l[2]; l' = {l[14:0], nb}.
REQ-020 On accept, the registers SHALL update in the same edge (all arithmetic mod 2^16, primes denote new values):
- lfsr' = step(lfsr)
- rs1' = rs1 + core_dec1_in
- rs3' = rs3 + core_dec2_out + lfsr'
- rs4' = rs4 + core_dec1_in + rs1'
- rs2' = rs2 + core_dec3_out + rs4'
REQ-021 On accept, block_cnt SHALL increment, saturating at 0xFFFF.
REQ-022 On iv_load, the block SHALL set rs1..rs4 from iv, lfsr <= iv[15:0] | 16'h1000 (never zero), block_cnt <= 0 and pt_valid <= 0.
REQ-023 iv_load SHALL have priority over any other event in the same cycle: no accept occurs and pending pt output is discarded.
REQ-024 In IDLE, ct_ready=0 and pt_valid=0; ct_valid is ignored.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, rs1..rs4=0, lfsr=0x0001, pt_data=0, pt_valid=0, block_cnt=0, ct_ready=0.
REQ-026 Reset asserted mid-operation SHALL discard the pending pt word; after release, the block SHALL remain in IDLE until iv_load.

Verification
REQ-027 Reset, then ct_valid=1 with no iv_load -> ct_ready=0, pt_valid=0, all outputs 0, block_cnt=0.
REQ-028 iv_load with iv=0x0001_0002_0003_0004 -> next cycle core_rs1..4 = 0x0001, 0x0002, 0x0003, 0x0004, lfsr=0x1004, state RUN, ct_ready=1.
REQ-029 Starting from REQ-028, accept one word with bench-driven core_dec1_in=0x0010, core_dec2_out=0x0020, core_dec3_out=0x0030, core_dataout=0xBEEF -> expected results:
- lfsr=0x2009, rs1=0x0011, rs2=0x0057, rs3=0x202C, rs4=0x0025
- pt_data=0xBEEF, pt_valid=1, block_cnt=1
REQ-030 pt_ready=0 for 5 cycles with ct_valid=1 -> ct_ready=0, pt_data, rs and block_cnt unchanged; pt_ready=1 with ct_valid=1 -> back-to-back accepts at 1 word/cycle.
REQ-031 iv_load asserted in the same cycle as ct_valid while pt_valid=1 -> no accept, pt_valid=0 next cycle, block_cnt=0, rs = new iv words.
REQ-032 Force block_cnt to 0xFFFE and accept 3 words -> block_cnt = 0xFFFF and stays 0xFFFF.

Source files
------------

// File: rtl/decryption_state_ctrl.sv
// Decryption state controller: holds the rs1..rs4 running-state words, an LFSR and a
// block counter, and sequences ciphertext/plaintext handshakes around an external datapath.
module decryption_state_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        iv_load,
   input  logic [63:0] iv,
   input  logic        ct_valid,
   output logic        ct_ready,
   input  logic [15:0] ct_data,
   output logic        pt_valid,
   input  logic        pt_ready,
   output logic [15:0] pt_data,
   output logic [15:0] core_datain,
   output logic [15:0] core_rs1,
   output logic [15:0] core_rs2,
   output logic [15:0] core_rs3,
   output logic [15:0] core_rs4,
   input  logic [15:0] core_dec1_in,
   input  logic [15:0] core_dec2_out,
   input  logic [15:0] core_dec3_out,
   input  logic [15:0] core_dataout,
   output logic [15:0] block_cnt
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] rs1_r;
   logic [15:0] rs2_r;
   logic [15:0] rs3_r;
   logic [15:0] rs4_r;
   logic [15:0] lfsr_r;
   logic [15:0] pt_data_r;
   logic        pt_valid_r;
   logic [15:0] blk_cnt_r;
   logic        ct_ready_s;
   logic        accept_s;
   logic [15:0] lfsr_next_s;
   logic [15:0] rs1_next_s;
   logic [15:0] rs2_next_s;
   logic [15:0] rs3_next_s;
   logic [15:0] rs4_next_s;
   logic [15:0] blk_cnt_next_s;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic nb;
      nb = l[15] ^ l[14] ^ l[11] ^ l[9] ^ l[6] ^ l[2];
      return {l[14:0], nb};
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: only iv_load leaves IDLE; RUN is left only by reset.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (iv_load) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            state_next_s = RUN;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Handshake: iv_load blocks acceptance; a stalled output word blocks new input.
   always_comb begin
      ct_ready_s = 1'b0;
      if ((state_r == RUN) && !iv_load && (!pt_valid_r || pt_ready)) begin
         ct_ready_s = 1'b1;
      end else begin
         ct_ready_s = 1'b0;
      end
      accept_s = ct_valid && ct_ready_s;
   end

   // Running-state updates; the chain order matters since rs4 uses rs1' and rs2 uses rs4'.
   always_comb begin
      lfsr_next_s = lfsr_step(lfsr_r);
      rs1_next_s  = rs1_r + core_dec1_in;
      rs3_next_s  = rs3_r + core_dec2_out + lfsr_next_s;
      rs4_next_s  = rs4_r + core_dec1_in + rs1_next_s;
      rs2_next_s  = rs2_r + core_dec3_out + rs4_next_s;
      if (blk_cnt_r == 16'hFFFF) begin
         blk_cnt_next_s = blk_cnt_r;
      end else begin
         blk_cnt_next_s = blk_cnt_r + 16'd1;
      end
   end

   // Datapath registers: iv_load wins over accept, accept wins over output drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_r      <= 16'd0;
         rs2_r      <= 16'd0;
         rs3_r      <= 16'd0;
         rs4_r      <= 16'd0;
         lfsr_r     <= 16'h0001;
         pt_data_r  <= 16'd0;
         pt_valid_r <= 1'b0;
         blk_cnt_r  <= 16'd0;
      end else if (iv_load) begin
         rs1_r      <= iv[63:48];
         rs2_r      <= iv[47:32];
         rs3_r      <= iv[31:16];
         rs4_r      <= iv[15:0];
         lfsr_r     <= iv[15:0] | 16'h1000;
         pt_valid_r <= 1'b0;
         blk_cnt_r  <= 16'd0;
      end else if (accept_s) begin
         rs1_r      <= rs1_next_s;
         rs2_r      <= rs2_next_s;
         rs3_r      <= rs3_next_s;
         rs4_r      <= rs4_next_s;
         lfsr_r     <= lfsr_next_s;
         pt_data_r  <= core_dataout;
         pt_valid_r <= 1'b1;
         blk_cnt_r  <= blk_cnt_next_s;
      end else if (pt_valid_r && pt_ready) begin
         pt_valid_r <= 1'b0;
      end else begin
         pt_valid_r <= pt_valid_r;
      end
   end

   assign ct_ready    = ct_ready_s;
   assign pt_valid    = pt_valid_r;
   assign pt_data     = pt_data_r;
   assign core_datain = ct_data;
   assign core_rs1    = rs1_r;
   assign core_rs2    = rs2_r;
   assign core_rs3    = rs3_r;
   assign core_rs4    = rs4_r;
   assign block_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_decryption_state_ctrl.sv
// Scoreboard bench for decryption_state_ctrl: stimulus pushes expected plaintext words,
// a negedge monitor pops them on every output transfer; register state is checked directly.
module tb_decryption_state_ctrl;

   logic        clk;
   logic        rst_n;
   logic        iv_load;
   logic [63:0] iv;
   logic        ct_valid;
   logic        ct_ready;
   logic [15:0] ct_data;
   logic        pt_valid;
   logic        pt_ready;
   logic [15:0] pt_data;
   logic [15:0] core_datain;
   logic [15:0] core_rs1, core_rs2, core_rs3, core_rs4;
   logic [15:0] core_dec1_in, core_dec2_out, core_dec3_out, core_dataout;
   logic [15:0] block_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] m_rs1, m_rs2, m_rs3, m_rs4, m_lfsr, m_cnt;

   decryption_state_ctrl dut (
      .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
      .core_datain(core_datain),
      .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rs3(core_rs3), .core_rs4(core_rs4),
      .core_dec1_in(core_dec1_in), .core_dec2_out(core_dec2_out),
      .core_dec3_out(core_dec3_out), .core_dataout(core_dataout),
      .block_cnt(block_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[14] ^ l[11] ^ l[9] ^ l[6] ^ l[2]};
   endfunction

   task automatic chk_state();
      chk("rs1", core_rs1, m_rs1);
      chk("rs2", core_rs2, m_rs2);
      chk("rs3", core_rs3, m_rs3);
      chk("rs4", core_rs4, m_rs4);
      chk("lfsr", dut.lfsr_r, m_lfsr);
      chk("block_cnt", block_cnt, m_cnt);
   endtask

   task automatic load_model(input logic [63:0] v);
      m_rs1 = v[63:48]; m_rs2 = v[47:32]; m_rs3 = v[31:16]; m_rs4 = v[15:0];
      m_lfsr = v[15:0] | 16'h1000;
      m_cnt = 16'd0;
   endtask

   // Offer one word that the bench expects to be accepted this cycle.
   task automatic send(input logic [15:0] ct, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [15:0] d3, input logic [15:0] dout);
      ct_valid = 1'b1; ct_data = ct;
      core_dec1_in = d1; core_dec2_out = d2; core_dec3_out = d3; core_dataout = dout;
      #1;
      chk("ct_ready_on_send", ct_ready, 1'b1);
      chk("core_datain", core_datain, ct);
      m_lfsr = ref_step(m_lfsr);
      m_rs1 = m_rs1 + d1;
      m_rs3 = m_rs3 + d2 + m_lfsr;
      m_rs4 = m_rs4 + d1 + m_rs1;
      m_rs2 = m_rs2 + d3 + m_rs4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      exp_q.push_back(dout);
      @(posedge clk); #1;
      ct_valid = 1'b0;
      chk("pt_valid_after_send", pt_valid, 1'b1);
      chk_state();
   endtask

   // Monitor: every transfer of a plaintext word must match the front of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && pt_valid && pt_ready && !iv_load) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pt_word", {48'd0, pt_data}, 64'hDEAD_DEAD_DEAD_DEAD);
         end else begin
            chk("pt_data", pt_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; iv_load = 1'b0; iv = 64'd0; ct_valid = 1'b0; ct_data = 16'd0;
      pt_ready = 1'b0; core_dec1_in = 16'd0; core_dec2_out = 16'd0;
      core_dec3_out = 16'd0; core_dataout = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ct_ready", ct_ready, 1'b0);
      chk("rst_pt_valid", pt_valid, 1'b0);
      chk("rst_pt_data", pt_data, 16'd0);
      chk("rst_rs", {core_rs1, core_rs2, core_rs3, core_rs4}, 64'd0);
      chk("rst_lfsr", dut.lfsr_r, 16'h0001);
      chk("rst_block_cnt", block_cnt, 16'd0);

      // No iv loaded yet: ct_valid must be ignored.
      rst_n = 1'b1; ct_valid = 1'b1; ct_data = 16'h1234; pt_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("idle_ct_ready", ct_ready, 1'b0);
         chk("idle_pt_valid", pt_valid, 1'b0);
         chk("idle_block_cnt", block_cnt, 16'd0);
         chk("idle_rs", {core_rs1, core_rs2, core_rs3, core_rs4}, 64'd0);
      end
      ct_valid = 1'b0; pt_ready = 1'b0;

      // Load iv and check the fixed values.
      iv_load = 1'b1; iv = 64'h0001_0002_0003_0004;
      @(posedge clk); #1;
      iv_load = 1'b0;
      load_model(64'h0001_0002_0003_0004);
      #1;
      chk("iv_rs", {core_rs1, core_rs2, core_rs3, core_rs4}, 64'h0001_0002_0003_0004);
      chk("iv_lfsr", dut.lfsr_r, 16'h1004);
      chk("iv_ct_ready", ct_ready, 1'b1);
      chk("iv_block_cnt", block_cnt, 16'd0);

      // First accepted word with hand-computed results.
      send(16'h5555, 16'h0010, 16'h0020, 16'h0030, 16'hBEEF);
      chk("w1_lfsr", dut.lfsr_r, 16'h2009);
      chk("w1_rs", {core_rs1, core_rs2, core_rs3, core_rs4}, 64'h0011_0057_202C_0025);
      chk("w1_pt_data", pt_data, 16'hBEEF);
      chk("w1_block_cnt", block_cnt, 16'd1);

      // Output stall: nothing may move for 5 cycles.
      ct_valid = 1'b1; ct_data = 16'h7777; core_dataout = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_ct_ready", ct_ready, 1'b0);
         @(posedge clk); #1;
         chk("stall_pt_valid", pt_valid, 1'b1);
         chk("stall_pt_data", pt_data, 16'hBEEF);
         chk_state();
      end
      ct_valid = 1'b0;

      // Release the stall and stream back-to-back words.
      pt_ready = 1'b1;
      send(16'hA001, 16'h1357, 16'h2468, 16'hFFFF, 16'hC0DE);
      send(16'hA002, 16'hFFF0, 16'h0001, 16'h8000, 16'h0F0F);
      send(16'hA003, 16'h0000, 16'h0000, 16'h0000, 16'hF00D);
      send(16'hA004, 16'h8001, 16'h7FFE, 16'h00FF, 16'h4321);
      @(posedge clk); #1;
      chk("drain_pt_valid", pt_valid, 1'b0);

      // iv_load collides with a pending word and a ct offer.
      pt_ready = 1'b0;
      send(16'hB001, 16'h0101, 16'h0202, 16'h0303, 16'h9999);
      iv_load = 1'b1; iv = 64'hA000_B000_C000_0005; ct_valid = 1'b1; pt_ready = 1'b1;
      #1;
      chk("ivcol_ct_ready", ct_ready, 1'b0);
      @(posedge clk); #1;
      iv_load = 1'b0; ct_valid = 1'b0;
      exp_q.delete();
      load_model(64'hA000_B000_C000_0005);
      #1;
      chk("ivcol_pt_valid", pt_valid, 1'b0);
      chk_state();
      chk("ivcol_ct_ready_after", ct_ready, 1'b1);

      // Counter saturation.
      force dut.blk_cnt_r = 16'hFFFE;
      #1;
      release dut.blk_cnt_r;
      m_cnt = 16'hFFFE;
      send(16'hC001, 16'h0011, 16'h0022, 16'h0033, 16'h5A5A);
      send(16'hC002, 16'h0044, 16'h0055, 16'h0066, 16'hA5A5);
      send(16'hC003, 16'h0077, 16'h0088, 16'h0099, 16'h3C3C);
      chk("sat_block_cnt", block_cnt, 16'hFFFF);

      // Reset in the middle of a pending word.
      @(posedge clk); #1;
      pt_ready = 1'b0;
      send(16'hD001, 16'h0001, 16'h0002, 16'h0003, 16'h7E7E);
      #1;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("midrst_pt_valid", pt_valid, 1'b0);
      chk("midrst_block_cnt", block_cnt, 16'd0);
      chk("midrst_rs1", core_rs1, 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; ct_valid = 1'b1; pt_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("postrst_ct_ready", ct_ready, 1'b0);
         @(posedge clk); #1;
         chk("postrst_pt_valid", pt_valid, 1'b0);
      end
      ct_valid = 1'b0;

      @(posedge clk); #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
